// File: rtl/bpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bpu_pkg
// Brief    : Shared types and helpers for the gshare branch prediction unit.
// Revision : 1.0 - initial release
// ============================================================================
package bpu_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } cnt_t;

    localparam int C_PC_W   = 32;
    // Byte offset is never stored; all tables work on the word address.
    localparam int C_WORD_W = C_PC_W - 2;

    typedef struct packed {
        logic                valid;
        logic [C_WORD_W-1:0] tag;
        logic [C_PC_W-1:0]   target;
        logic                is_jmp;
    } btb_entry_t;

    function automatic int idx_w(input int entries);
        return $clog2(entries);
    endfunction

    function automatic int tag_w(input int entries);
        return C_WORD_W - $clog2(entries);
    endfunction

    function automatic cnt_t sat_inc(input cnt_t c);
        case (c)
            SNT:     return WNT;
            WNT:     return WT;
            default: return ST;
        endcase
    endfunction

    function automatic cnt_t sat_dec(input cnt_t c);
        case (c)
            ST:      return WT;
            WT:      return WNT;
            default: return SNT;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/bpu_btb.sv
`default_nettype none
// ============================================================================
// Module   : bpu_btb
// Brief    : Direct-mapped branch target buffer, one read port, one write port.
// Revision : 1.0 - initial release
// ============================================================================
module bpu_btb
    import bpu_pkg::*;
#(
    parameter int BTB_ENTRIES = 64
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [C_WORD_W-1:0] i_rd_addr,
    output logic                o_rd_hit,
    output logic [C_PC_W-1:0]   o_rd_target,
    output logic                o_rd_is_jmp,
    input  logic                i_wr_en,
    input  logic [C_WORD_W-1:0] i_wr_addr,
    input  logic [C_PC_W-1:0]   i_wr_target,
    input  logic                i_wr_is_jmp
);

    localparam int C_IDX_W = idx_w(BTB_ENTRIES);
    localparam int C_TAG_W = tag_w(BTB_ENTRIES);

    btb_entry_t          r_mem [BTB_ENTRIES];
    btb_entry_t          w_rd_entry;
    logic [C_IDX_W-1:0]  w_rd_idx;
    logic [C_IDX_W-1:0]  w_wr_idx;
    logic [C_WORD_W-1:0] w_rd_tag;
    logic [C_WORD_W-1:0] w_wr_tag;

    assign w_rd_idx = i_rd_addr[C_IDX_W-1:0];
    assign w_wr_idx = i_wr_addr[C_IDX_W-1:0];
    assign w_rd_tag = C_WORD_W'(i_rd_addr[C_WORD_W-1:C_WORD_W-C_TAG_W]);
    assign w_wr_tag = C_WORD_W'(i_wr_addr[C_WORD_W-1:C_WORD_W-C_TAG_W]);

    assign w_rd_entry  = r_mem[w_rd_idx];
    assign o_rd_hit    = w_rd_entry.valid && (w_rd_entry.tag == w_rd_tag);
    assign o_rd_target = w_rd_entry.target;
    assign o_rd_is_jmp = w_rd_entry.is_jmp;

    // Newer writer simply replaces whatever lived in the slot.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                r_mem[i].valid <= 1'b0;
            end
        end else if (i_wr_en) begin
            r_mem[w_wr_idx] <= '{valid:  1'b1,
                                 tag:    w_wr_tag,
                                 target: i_wr_target,
                                 is_jmp: i_wr_is_jmp};
        end
    end

endmodule
`default_nettype wire

// File: rtl/bpu_gshare.sv
`default_nettype none
// ============================================================================
// Module   : bpu_gshare
// Brief    : gshare direction predictor + BTB with resolve/redirect and stats.
// Revision : 1.0 - initial release
// ============================================================================
module bpu_gshare
    import bpu_pkg::*;
#(
    parameter int BHT_ENTRIES = 256,
    parameter int BTB_ENTRIES = 64,
    parameter int GHR_W       = 8,
    parameter int CNT_W       = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [31:0]      i_f_pc,
    input  logic             i_f_stall,
    output logic             o_f_pred_taken,
    output logic [31:0]      o_f_pred_target,
    output logic [GHR_W-1:0] o_f_ghr,
    input  logic             i_u_vld,
    input  logic [31:0]      i_u_pc,
    input  logic             i_u_is_br,
    input  logic             i_u_is_jmp,
    input  logic             i_u_taken,
    input  logic [31:0]      i_u_target,
    input  logic             i_u_pred_taken,
    input  logic [31:0]      i_u_pred_target,
    input  logic [GHR_W-1:0] i_u_ghr,
    output logic             o_mispred,
    output logic [31:0]      o_redirect_pc,
    output logic [CNT_W-1:0] o_br_cnt,
    output logic [CNT_W-1:0] o_mispred_cnt
);

    localparam int C_BHT_IDX_W = idx_w(BHT_ENTRIES);

    cnt_t                   r_bht [BHT_ENTRIES];
    logic [GHR_W-1:0]       r_ghr;
    logic [CNT_W-1:0]       r_br_cnt;
    logic [CNT_W-1:0]       r_mispred_cnt;

    logic [C_BHT_IDX_W-1:0] w_f_idx;
    logic [C_BHT_IDX_W-1:0] w_u_idx;
    cnt_t                   w_f_cnt;
    logic                   w_hit;
    logic                   w_btb_is_jmp;
    logic [31:0]            w_btb_target;
    logic                   w_f_taken;
    logic                   w_u_ctl;
    logic                   w_mispred;

    bpu_btb #(
        .BTB_ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_rd_addr   (i_f_pc[31:2]),
        .o_rd_hit    (w_hit),
        .o_rd_target (w_btb_target),
        .o_rd_is_jmp (w_btb_is_jmp),
        .i_wr_en     (w_u_ctl && i_u_taken),
        .i_wr_addr   (i_u_pc[31:2]),
        .i_wr_target (i_u_target),
        .i_wr_is_jmp (i_u_is_jmp)
    );

    // Lookup
    assign w_f_idx   = i_f_pc[C_BHT_IDX_W+1:2] ^ C_BHT_IDX_W'(r_ghr);
    assign w_f_cnt   = r_bht[w_f_idx];
    assign w_f_taken = w_hit && (w_btb_is_jmp || w_f_cnt == WT || w_f_cnt == ST);

    assign o_f_pred_taken  = !i_reset && w_f_taken;
    assign o_f_pred_target = i_reset ? 32'd0 : (w_hit ? w_btb_target : i_f_pc + 32'd4);
    assign o_f_ghr         = r_ghr;

    // Resolve
    assign w_u_idx   = i_u_pc[C_BHT_IDX_W+1:2] ^ C_BHT_IDX_W'(i_u_ghr);
    assign w_u_ctl   = i_u_vld && (i_u_is_br || i_u_is_jmp);
    assign w_mispred = w_u_ctl && ((i_u_taken != i_u_pred_taken) ||
                                   (i_u_taken && (i_u_target != i_u_pred_target)));

    assign o_mispred     = !i_reset && w_mispred;
    assign o_redirect_pc = i_reset ? 32'd0 : (i_u_taken ? i_u_target : i_u_pc + 32'd4);
    assign o_br_cnt      = r_br_cnt;
    assign o_mispred_cnt = r_mispred_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                r_bht[i] <= WNT;
            end
        end else if (w_u_ctl && i_u_is_br) begin
            r_bht[w_u_idx] <= i_u_taken ? sat_inc(r_bht[w_u_idx]) : sat_dec(r_bht[w_u_idx]);
        end
    end

    // Repair from the resolving insn outranks the speculative fetch shift.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ghr <= '0;
        end else if (w_mispred) begin
            r_ghr <= i_u_is_br ? GHR_W'({i_u_ghr, i_u_taken}) : i_u_ghr;
        end else if (!i_f_stall && w_hit && !w_btb_is_jmp) begin
            r_ghr <= GHR_W'({r_ghr, w_f_taken});
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_br_cnt      <= '0;
            r_mispred_cnt <= '0;
        end else begin
            if (w_u_ctl && (r_br_cnt != '1)) begin
                r_br_cnt <= r_br_cnt + CNT_W'(1);
            end
            if (w_mispred && (r_mispred_cnt != '1)) begin
                r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bpu_gshare.sv
`default_nettype none
// ============================================================================
// Module   : tb_bpu_gshare
// Brief    : Directed bench for bpu_gshare with a per-cycle reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bpu_gshare;

    localparam int BHT = 256;
    localparam int BTB = 128;   // 0x100 and 0x200 must not alias
    localparam int GW  = 8;
    localparam int CW  = 4;     // small enough to reach saturation

    logic          i_clk = 1'b0;
    logic          i_reset;
    logic [31:0]   i_f_pc;
    logic          i_f_stall;
    logic          o_f_pred_taken;
    logic [31:0]   o_f_pred_target;
    logic [GW-1:0] o_f_ghr;
    logic          i_u_vld, i_u_is_br, i_u_is_jmp, i_u_taken, i_u_pred_taken;
    logic [31:0]   i_u_pc, i_u_target, i_u_pred_target;
    logic [GW-1:0] i_u_ghr;
    logic          o_mispred;
    logic [31:0]   o_redirect_pc;
    logic [CW-1:0] o_br_cnt, o_mispred_cnt;

    always #5 i_clk = ~i_clk;

    bpu_gshare #(.BHT_ENTRIES(BHT), .BTB_ENTRIES(BTB), .GHR_W(GW), .CNT_W(CW)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_f_pc(i_f_pc), .i_f_stall(i_f_stall),
        .o_f_pred_taken(o_f_pred_taken), .o_f_pred_target(o_f_pred_target), .o_f_ghr(o_f_ghr),
        .i_u_vld(i_u_vld), .i_u_pc(i_u_pc), .i_u_is_br(i_u_is_br), .i_u_is_jmp(i_u_is_jmp),
        .i_u_taken(i_u_taken), .i_u_target(i_u_target), .i_u_pred_taken(i_u_pred_taken),
        .i_u_pred_target(i_u_pred_target), .i_u_ghr(i_u_ghr), .o_mispred(o_mispred),
        .o_redirect_pc(o_redirect_pc), .o_br_cnt(o_br_cnt), .o_mispred_cnt(o_mispred_cnt)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: counters as integers 0..3, BTB holding the full PC.
    int unsigned m_bht [BHT];
    bit          m_v   [BTB];
    logic [31:0] m_pc  [BTB];
    logic [31:0] m_tgt [BTB];
    bit          m_j   [BTB];
    int unsigned m_ghr, m_br, m_mp;
    bit          m_started = 1'b0;
    bit          e_hit, e_jmp, e_pt, e_mp, e_ctl;
    logic [31:0] e_tgt, e_rd;
    localparam int unsigned SAT = (1 << CW) - 1;

    task automatic model_eval();
        int unsigned bi, ti;
        bi    = ((i_f_pc >> 2) % BHT) ^ m_ghr;
        ti    = (i_f_pc >> 2) % BTB;
        e_hit = m_v[ti] && ((m_pc[ti] >> 2) == (i_f_pc >> 2));
        e_jmp = m_j[ti];
        e_pt  = !i_reset && e_hit && (m_j[ti] || m_bht[bi] >= 2);
        e_tgt = i_reset ? 32'd0 : (e_hit ? m_tgt[ti] : i_f_pc + 32'd4);
        e_ctl = i_u_vld && (i_u_is_br || i_u_is_jmp);
        e_mp  = !i_reset && e_ctl && ((i_u_taken != i_u_pred_taken) ||
                                      (i_u_taken && i_u_target != i_u_pred_target));
        e_rd  = i_reset ? 32'd0 : (i_u_taken ? i_u_target : i_u_pc + 32'd4);
    endtask

    always @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < BHT; i++) m_bht[i] = 1;
            for (int i = 0; i < BTB; i++) m_v[i] = 1'b0;
            m_ghr = 0; m_br = 0; m_mp = 0;
            m_started = 1'b1;
        end else if (m_started) begin
            int unsigned ui, ti;
            model_eval();
            if (e_ctl) begin
                if (i_u_is_br) begin
                    ui = ((i_u_pc >> 2) % BHT) ^ i_u_ghr;
                    if (i_u_taken) m_bht[ui] = (m_bht[ui] == 3) ? 3 : m_bht[ui] + 1;
                    else           m_bht[ui] = (m_bht[ui] == 0) ? 0 : m_bht[ui] - 1;
                end
                if (i_u_taken) begin
                    ti = (i_u_pc >> 2) % BTB;
                    m_v[ti] = 1'b1; m_pc[ti] = i_u_pc; m_tgt[ti] = i_u_target; m_j[ti] = i_u_is_jmp;
                end
                if (m_br < SAT) m_br++;
                if (e_mp && m_mp < SAT) m_mp++;
            end
            if (e_mp)
                m_ghr = i_u_is_br ? ((i_u_ghr * 2 + i_u_taken) % (1 << GW)) : i_u_ghr;
            else if (!i_f_stall && e_hit && !e_jmp)
                m_ghr = (m_ghr * 2 + e_pt) % (1 << GW);
        end
    end

    always @(negedge i_clk) begin
        if (m_started) begin
            model_eval();
            chk("cyc_pred_taken",  o_f_pred_taken,  e_pt);
            chk("cyc_pred_target", o_f_pred_target, e_tgt);
            chk("cyc_ghr",         o_f_ghr,         m_ghr);
            chk("cyc_mispred",     o_mispred,       e_mp);
            chk("cyc_redirect",    o_redirect_pc,   e_rd);
            chk("cyc_br_cnt",      o_br_cnt,        m_br);
            chk("cyc_mispred_cnt", o_mispred_cnt,   m_mp);
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_u(input logic vld, input logic [31:0] pc, input logic br, input logic jmp,
                         input logic tk, input logic [31:0] tgt, input logic pt,
                         input logic [31:0] ptgt, input logic [GW-1:0] ghr);
        i_u_vld = vld; i_u_pc = pc; i_u_is_br = br; i_u_is_jmp = jmp; i_u_taken = tk;
        i_u_target = tgt; i_u_pred_taken = pt; i_u_pred_target = ptgt; i_u_ghr = ghr;
    endtask

    task automatic idle_u();
        set_u(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, '0);
    endtask

    initial begin
        i_reset = 1'b1; i_f_pc = 32'h100; i_f_stall = 1'b0; idle_u();
        tick(); tick(); tick();
        chk("rst_pred_target", o_f_pred_target, 32'h0);
        chk("rst_pred_taken",  o_f_pred_taken,  1'b0);

        // Cold lookup
        i_reset = 1'b0; #1;
        chk("cold_taken",  o_f_pred_taken,  1'b0);
        chk("cold_target", o_f_pred_target, 32'h104);
        chk("cold_ghr",    o_f_ghr,         8'h00);

        // First taken beq, predicted not-taken
        i_f_stall = 1'b1;
        set_u(1, 32'h100, 1, 0, 1, 32'h80, 0, 32'h104, 8'h00); #1;
        chk("beq_mispred",  o_mispred,     1'b1);
        chk("beq_redirect", o_redirect_pc, 32'h80);
        tick(); idle_u(); #1;
        chk("beq_mp_cnt",  o_mispred_cnt,   4'd1);
        chk("beq_ghr",     o_f_ghr,         8'h01);
        chk("beq_hit_tgt", o_f_pred_target, 32'h80);
        chk("beq_hit_nt",  o_f_pred_taken,  1'b0);

        // Train counter at 0x40^1, then jal repair restores ghr=1
        set_u(1, 32'h100, 1, 0, 1, 32'h80, 0, 32'h104, 8'h01); tick();
        chk("beq2_ghr", o_f_ghr, 8'h03);
        set_u(1, 32'h200, 0, 1, 1, 32'h400, 0, 32'h204, 8'h01); #1;
        chk("jal_redirect", o_redirect_pc, 32'h400);
        tick(); idle_u(); #1;
        chk("jal_ghr", o_f_ghr, 8'h01);
        i_f_stall = 1'b0; #1;
        chk("wt_taken",  o_f_pred_taken,  1'b1);
        chk("wt_target", o_f_pred_target, 32'h80);
        tick();
        chk("spec_ghr", o_f_ghr, 8'h03);
        i_f_pc = 32'h200; #1;
        chk("jal_pred_taken",  o_f_pred_taken,  1'b1);
        chk("jal_pred_target", o_f_pred_target, 32'h400);
        tick();
        chk("jal_no_shift", o_f_ghr, 8'h03);
        i_f_stall = 1'b1; i_f_pc = 32'h100;

        // Not-taken four times, then one taken: counter must land on WNT
        set_u(1, 32'h100, 1, 0, 0, 32'h80, 1, 32'h80, 8'h01); #1;
        chk("nt_redirect", o_redirect_pc, 32'h104);
        tick();
        chk("nt_repair_ghr", o_f_ghr, 8'h02);
        for (int k = 0; k < 3; k++) begin
            set_u(1, 32'h100, 1, 0, 0, 32'h80, 0, 32'h104, 8'h01); #1;
            chk("nt_no_mispred", o_mispred, 1'b0);
            tick();
        end
        set_u(1, 32'h100, 1, 0, 1, 32'h80, 0, 32'h104, 8'h01); tick();
        set_u(1, 32'h200, 0, 1, 1, 32'h400, 0, 32'h204, 8'h01); tick();
        idle_u(); #1;
        chk("sat_ghr",   o_f_ghr,        8'h01);
        chk("sat_taken", o_f_pred_taken, 1'b0);

        // Repair beats speculative shift on a fetch-hit conditional
        i_f_stall = 1'b0;
        set_u(1, 32'h104, 1, 0, 1, 32'h500, 0, 32'h108, 8'h5A); tick();
        idle_u(); i_f_stall = 1'b1; #1;
        chk("repair_ghr", o_f_ghr, 8'hB5);
        tick();
        chk("stall_ghr", o_f_ghr, 8'hB5);

        // Wrong target on a correctly-predicted-taken branch
        set_u(1, 32'h100, 1, 0, 1, 32'h90, 1, 32'h80, 8'hB5); #1;
        chk("tgt_mispred",  o_mispred,     1'b1);
        chk("tgt_redirect", o_redirect_pc, 32'h90);
        tick(); idle_u(); #1;
        chk("tgt_btb", o_f_pred_target, 32'h90);
        chk("tgt_ghr", o_f_ghr,         8'h6B);

        // Non-control insn is ignored
        set_u(1, 32'h108, 0, 0, 1, 32'h900, 0, 32'h10C, 8'h00); #1;
        chk("nonctl_mispred", o_mispred, 1'b0);
        tick(); idle_u(); #1;
        chk("nonctl_br_cnt", o_br_cnt,      4'd11);
        chk("nonctl_mp_cnt", o_mispred_cnt, 4'd8);

        // BTB conflict: 0x300 evicts 0x100
        set_u(1, 32'h300, 1, 0, 1, 32'h700, 0, 32'h304, 8'h00); tick();
        idle_u(); #1;
        chk("evict_target", o_f_pred_target, 32'h104);
        i_f_pc = 32'h300; #1;
        chk("new_target", o_f_pred_target, 32'h700);

        // Statistic counter saturation
        for (int k = 0; k < 5; k++) begin
            set_u(1, 32'h200, 0, 1, 1, 32'h400, 1, 32'h400, 8'h00); tick();
        end
        idle_u(); #1;
        chk("br_cnt_sat", o_br_cnt,      4'd15);
        chk("mp_cnt_mid", o_mispred_cnt, 4'd9);
        for (int k = 0; k < 7; k++) begin
            set_u(1, 32'h200, 0, 1, 1, 32'h400, 0, 32'h204, 8'h00); tick();
        end
        idle_u(); #1;
        chk("mp_cnt_sat", o_mispred_cnt, 4'd15);

        // Reset mid-stream dominates a pending mispredict
        i_reset = 1'b1; i_f_pc = 32'h200;
        set_u(1, 32'h200, 0, 1, 1, 32'h400, 0, 32'h204, 8'h33); #1;
        chk("mid_rst_mispred",  o_mispred,      1'b0);
        chk("mid_rst_redirect", o_redirect_pc,  32'h0);
        chk("mid_rst_taken",    o_f_pred_taken, 1'b0);
        tick();
        i_reset = 1'b0; idle_u(); #1;
        chk("post_rst_br_cnt", o_br_cnt,        4'd0);
        chk("post_rst_mp_cnt", o_mispred_cnt,   4'd0);
        chk("post_rst_target", o_f_pred_target, 32'h204);
        chk("post_rst_ghr",    o_f_ghr,         8'h00);
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
